// File: rtl/red_pitaya_na_sweeper.sv
// Network-analyzer sweep master: steps the IQ frequency, waits out averaging, reads the sums and queues results.
// Define NA_SWEEP_TIMEOUT_EN to enable the ack watchdog; otherwise the master waits for ack forever.
module red_pitaya_na_sweeper #(
  parameter int FIFO_AW  = 2,
  parameter int POLL_GAP = 15,
  parameter int TIMEOUT  = 1023
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [31:0]  f_start_i,
  input  logic [31:0]  f_step_i,
  input  logic [15:0]  n_points_i,
  output logic [15:0]  m_addr_o,
  output logic         m_wen_o,
  output logic         m_ren_o,
  output logic [31:0]  m_wdata_o,
  input  logic         m_ack_i,
  input  logic [31:0]  m_rdata_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [139:0] res_data_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         timeout_err_o
);

  localparam int          DEPTH  = 1 << FIFO_AW;
  localparam logic [15:0] A_FREQ = 16'h0108;
  localparam logic [15:0] A_STAT = 16'h0140;

  // state   | meaning
  // IDLE    | waiting for start_i
  // WR_FREQ | frequency write strobe / ack wait
  // POLL    | busy-flag read strobe / ack wait
  // GAP     | idle spacing between busy polls
  // RD      | four sum-word reads, strobe / ack wait each
  // PUSH    | waiting for FIFO room, then queue the point
  // DONE    | one-cycle done_o pulse
  typedef enum logic [2:0] {
    S_IDLE, S_WR_FREQ, S_POLL, S_GAP, S_RD, S_PUSH, S_DONE
  } state_t;

  state_t             state;
  logic [31:0]        f_cur, f_step;
  logic [15:0]        n_pts, k;
  logic [1:0]         rd_idx;
  logic [30:0]        rd_w [4];
  logic [15:0]        gap_cnt;
  logic               abort_q;
  logic [139:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               strobe, ack_ok, abort_now, pop, push, tmo_hit;
  logic [31:0]        f_next;

  assign strobe      = m_wen_o | m_ren_o;
  // the strobe cycle itself never counts as an ack
  assign ack_ok      = m_ack_i & ~strobe;
  assign abort_now   = abort_q | abort_i;
  assign f_next      = f_cur + f_step;
  assign res_valid_o = (count != '0);
  assign pop         = res_valid_o & res_ready_i;
  assign push        = (state == S_PUSH) & ((count != (FIFO_AW+1)'(DEPTH)) | pop);
  assign res_data_o  = res_valid_o ? mem[rd_ptr] : '0;

`ifdef NA_SWEEP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_err_q;
  logic             in_bus;

  assign in_bus        = (state == S_WR_FREQ) | (state == S_POLL) | (state == S_RD);
  assign tmo_hit       = ~strobe & ~m_ack_i & (tmo_cnt == TMO_W'(1));
  assign timeout_err_o = tmo_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (strobe)
        tmo_cnt <= TMO_W'(TIMEOUT - 1);
      else if (tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - TMO_W'(1);
      if (state == S_IDLE && start_i)
        tmo_err_q <= 1'b0;
      else if (in_bus && tmo_hit)
        tmo_err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit       = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      f_cur     <= '0;
      f_step    <= '0;
      n_pts     <= '0;
      k         <= '0;
      rd_idx    <= '0;
      gap_cnt   <= '0;
      abort_q   <= 1'b0;
      m_addr_o  <= '0;
      m_wdata_o <= '0;
      m_wen_o   <= 1'b0;
      m_ren_o   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      if (state != S_IDLE && abort_i)
        abort_q <= 1'b1;
      case (state)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (start_i) begin
            f_cur  <= f_start_i;
            f_step <= f_step_i;
            n_pts  <= n_points_i;
            k      <= '0;
            busy_o <= 1'b1;
            if (n_points_i == '0) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end else begin
              state     <= S_WR_FREQ;
              m_wen_o   <= 1'b1;
              m_addr_o  <= A_FREQ;
              m_wdata_o <= f_start_i;
            end
          end
        end
        S_WR_FREQ, S_POLL, S_RD: begin
          m_wen_o <= 1'b0;
          m_ren_o <= 1'b0;
          if (ack_ok) begin
            if (abort_now) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end else if (state == S_WR_FREQ) begin
              state    <= S_POLL;
              m_ren_o  <= 1'b1;
              m_addr_o <= A_STAT;
            end else if (state == S_POLL) begin
              if (m_rdata_i[31]) begin
                state   <= S_GAP;
                gap_cnt <= 16'(POLL_GAP - 1);
              end else begin
                state    <= S_RD;
                rd_idx   <= 2'd0;
                m_ren_o  <= 1'b1;
                m_addr_o <= A_STAT;
              end
            end else if (rd_idx == 2'd3) begin
              state <= S_PUSH;
            end else begin
              rd_idx   <= rd_idx + 2'd1;
              m_ren_o  <= 1'b1;
              m_addr_o <= A_STAT + {12'd0, rd_idx + 2'd1, 2'b00};
            end
          end else if (tmo_hit) begin
            state  <= S_DONE;
            done_o <= 1'b1;
          end
        end
        S_GAP: begin
          if (abort_now) begin
            state  <= S_DONE;
            done_o <= 1'b1;
          end else if (gap_cnt == '0) begin
            state    <= S_POLL;
            m_ren_o  <= 1'b1;
            m_addr_o <= A_STAT;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        S_PUSH: begin
          if (push) begin
            if (abort_now || k == n_pts - 16'd1) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end else begin
              k         <= k + 16'd1;
              f_cur     <= f_next;
              state     <= S_WR_FREQ;
              m_wen_o   <= 1'b1;
              m_addr_o  <= A_FREQ;
              m_wdata_o <= f_next;
            end
          end else if (abort_now) begin
            state  <= S_DONE;
            done_o <= 1'b1;
          end
        end
        S_DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == S_RD && ack_ok)
      rd_w[rd_idx] <= m_rdata_i[30:0];
  end

  // entry layout: {idx, i_sum[61:31], i_sum[30:0], q_sum[61:31], q_sum[30:0]}
  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr] <= {k, rd_w[1], rd_w[0], rd_w[3], rd_w[2]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_red_pitaya_na_sweeper.sv
// Bench for red_pitaya_na_sweeper: randomized IQ slave and consumer, sweep results checked against an arithmetic model.
module tb_red_pitaya_na_sweeper;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic [31:0]  f_start_i = '0;
  logic [31:0]  f_step_i = '0;
  logic [15:0]  n_points_i = '0;
  logic [15:0]  m_addr_o;
  logic         m_wen_o, m_ren_o;
  logic [31:0]  m_wdata_o;
  logic         m_ack_i = 1'b0;
  logic [31:0]  m_rdata_i = '0;
  logic         res_valid_o;
  logic         res_ready_i = 1'b0;
  logic [139:0] res_data_o;
  logic         busy_o, done_o, timeout_err_o;

  int checks = 0;
  int errors = 0;

  red_pitaya_na_sweeper dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .f_start_i(f_start_i), .f_step_i(f_step_i), .n_points_i(n_points_i),
    .m_addr_o(m_addr_o), .m_wen_o(m_wen_o), .m_ren_o(m_ren_o), .m_wdata_o(m_wdata_o),
    .m_ack_i(m_ack_i), .m_rdata_i(m_rdata_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .busy_o(busy_o), .done_o(done_o), .timeout_err_o(timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  // slave / consumer configuration, written only by the main sequence
  bit ack_en = 1'b1;
  int dly_lo = 0, dly_hi = 0, busy_lo = 0, busy_hi = 0, rdy_mode = 2;

  // slave state and logs, written only by the slave process
  bit           pend = 1'b0;
  int           dly = 0, busy_left = 0;
  int           n_stb = 0, rd144_cnt = 0, proto_err = 0;
  logic [61:0]  cur_i = '0, cur_q = '0;
  logic [31:0]  rsp = '0, junk;
  logic [15:0]  stb_addr = '0;
  logic [63:0]  r64;
  logic [31:0]  wr_q [$];
  logic [123:0] sum_q [$];

  always @(negedge clk_i) begin
    m_ack_i = 1'b0;
    if (rst_i) begin
      pend = 1'b0;
    end else begin
      if (pend && ack_en) begin
        if (dly == 0) begin
          if (m_addr_o !== stb_addr) proto_err++;
          m_ack_i   = 1'b1;
          m_rdata_i = rsp;
          pend      = 1'b0;
        end else begin
          dly--;
        end
      end
      if (m_wen_o || m_ren_o) begin
        if (pend || (m_wen_o && m_ren_o)) proto_err++;
        n_stb++;
        pend     = 1'b1;
        stb_addr = m_addr_o;
        dly      = $urandom_range(dly_hi, dly_lo);
        junk     = $urandom;
        if (m_wen_o) begin
          if (m_addr_o !== 16'h0108) proto_err++;
          wr_q.push_back(m_wdata_o);
          r64   = {$urandom, $urandom};
          cur_i = r64[61:0];
          r64   = {$urandom, $urandom};
          cur_q = r64[61:0];
          sum_q.push_back({cur_i, cur_q});
          busy_left = $urandom_range(busy_hi, busy_lo);
          rsp = junk;
        end else begin
          case (m_addr_o)
            16'h0140: begin
              if (busy_left > 0) begin
                busy_left--;
                rsp = {1'b1, junk[30:0]};
              end else begin
                rsp = {1'b0, cur_i[30:0]};
              end
            end
            16'h0144: begin
              rsp = {junk[31], cur_i[61:31]};
              rd144_cnt++;
            end
            16'h0148: rsp = {junk[31], cur_q[30:0]};
            16'h014C: rsp = {junk[31], cur_q[61:31]};
            default: begin
              proto_err++;
              rsp = junk;
            end
          endcase
        end
      end
    end
  end

  logic [139:0] got_q [$];
  int n_done = 0;

  always @(negedge clk_i) begin
    case (rdy_mode)
      0:       res_ready_i = 1'b0;
      1:       res_ready_i = 1'($urandom_range(1, 0));
      default: res_ready_i = 1'b1;
    endcase
    if (!rst_i && res_valid_o && res_ready_i) got_q.push_back(res_data_o);
    if (!rst_i && done_o) n_done++;
  end

  task automatic chk(input string tag, input logic [139:0] obs, input logic [139:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // leaves the caller at the negedge of the cycle right after the accepting edge
  task automatic start_sweep(input logic [31:0] fs, input logic [31:0] st, input logic [15:0] n,
                             input bit with_abort);
    @(negedge clk_i);
    f_start_i = fs; f_step_i = st; n_points_i = n;
    start_i = 1'b1; abort_i = with_abort;
    @(negedge clk_i);
    start_i = 1'b0; abort_i = 1'b0;
    f_start_i = $urandom; f_step_i = $urandom; n_points_i = 16'($urandom);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int c = 0;
    while (done_o !== 1'b1 && c < budget) begin
      @(negedge clk_i);
      c++;
    end
    chk({tag, ":done_seen"}, done_o, 1);
    chk({tag, ":busy_at_done"}, busy_o, 1);
  endtask

  task automatic check_sweep(input string tag, input int bw, input int bg,
                             input logic [31:0] fs, input logic [31:0] st, input int n);
    chk({tag, ":writes"}, wr_q.size() - bw, n);
    chk({tag, ":entries"}, got_q.size() - bg, n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] ef;
      ef = fs + 32'(k) * st;
      if (bw + k < wr_q.size()) chk($sformatf("%s:freq%0d", tag, k), wr_q[bw + k], ef);
      if (bg + k < got_q.size() && bw + k < sum_q.size())
        chk($sformatf("%s:entry%0d", tag, k), got_q[bg + k], {16'(k), sum_q[bw + k]});
    end
  endtask

  initial begin
    int bw, bg, nd, s, c, rc;
    logic [31:0] fs, st;
    int n;

    repeat (3) @(negedge clk_i);
    chk("rst:busy", busy_o, 0);
    chk("rst:done", done_o, 0);
    chk("rst:wen", m_wen_o, 0);
    chk("rst:ren", m_ren_o, 0);
    chk("rst:addr", m_addr_o, 0);
    chk("rst:valid", res_valid_o, 0);
    chk("rst:data", res_data_o, 0);
    chk("rst:tmo", timeout_err_o, 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // directed sweep, 5 busy polls per point, immediate acks
    busy_lo = 5; busy_hi = 5; dly_lo = 0; dly_hi = 0; rdy_mode = 2;
    bw = wr_q.size(); bg = got_q.size(); nd = n_done;
    start_sweep(32'd1000, 32'd500, 16'd3, 1'b0);
    chk("t1:wen", m_wen_o, 1);
    chk("t1:addr", m_addr_o, 16'h0108);
    chk("t1:wdata", m_wdata_o, 32'd1000);
    chk("t1:busy", busy_o, 1);
    wait_done(5000, "t1");
    repeat (4) @(negedge clk_i);
    chk("t1:done_pulses", n_done - nd, 1);
    chk("t1:busy_end", busy_o, 0);
    check_sweep("t1", bw, bg, 32'd1000, 32'd500, 3);

    // frequency wrap; abort coinciding with start in IDLE is ignored
    busy_lo = 0; busy_hi = 2; dly_hi = 2;
    bw = wr_q.size(); bg = got_q.size();
    start_sweep(32'hFFFF_FF00, 32'h100, 16'd2, 1'b1);
    wait_done(5000, "wrap");
    repeat (4) @(negedge clk_i);
    check_sweep("wrap", bw, bg, 32'hFFFF_FF00, 32'h100, 2);

    // zero points: straight to DONE with no bus traffic
    s = n_stb; nd = n_done;
    start_sweep(32'd7, 32'd7, 16'd0, 1'b0);
    chk("n0:busy", busy_o, 1);
    chk("n0:done", done_o, 1);
    chk("n0:wen", m_wen_o, 0);
    repeat (5) @(negedge clk_i);
    chk("n0:strobes", n_stb - s, 0);
    chk("n0:done_pulses", n_done - nd, 1);
    chk("n0:busy_end", busy_o, 0);

    // randomized sweeps with random slave latency and consumer backpressure
    for (int it = 0; it < 3; it++) begin
      fs = $urandom; st = $urandom; n = $urandom_range(6, 1);
      dly_lo = 0; dly_hi = 3; busy_lo = 0; busy_hi = 3; rdy_mode = 1;
      bw = wr_q.size(); bg = got_q.size();
      start_sweep(fs, st, 16'(n), 1'b0);
      chk($sformatf("rnd%0d:wdata", it), m_wdata_o, fs);
      wait_done(8000, $sformatf("rnd%0d", it));
      rdy_mode = 2;
      repeat (10) @(negedge clk_i);
      check_sweep($sformatf("rnd%0d", it), bw, bg, fs, st, n);
    end

    // backpressure: FIFO fills, sweeper stalls without strobes, start while busy ignored
    dly_lo = 0; dly_hi = 1; busy_lo = 0; busy_hi = 2; rdy_mode = 0;
    fs = $urandom; st = $urandom;
    bw = wr_q.size(); bg = got_q.size();
    start_sweep(fs, st, 16'd6, 1'b0);
    c = 0;
    while (wr_q.size() - bw < 5 && c < 3000) begin
      @(negedge clk_i);
      c++;
    end
    repeat (200) @(negedge clk_i);
    s = n_stb;
    start_i = 1'b1; f_start_i = $urandom; n_points_i = 16'd1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (200) @(negedge clk_i);
    chk("bp:no_strobes", n_stb - s, 0);
    chk("bp:writes_stalled", wr_q.size() - bw, 5);
    chk("bp:nothing_popped", got_q.size() - bg, 0);
    chk("bp:valid", res_valid_o, 1);
    chk("bp:busy", busy_o, 1);
    rdy_mode = 2;
    wait_done(3000, "bp");
    repeat (6) @(negedge clk_i);
    check_sweep("bp", bw, bg, fs, st, 6);

    // abort while a read is outstanding in point 1
    dly_lo = 4; dly_hi = 4; busy_lo = 0; busy_hi = 1; rdy_mode = 2;
    bw = wr_q.size(); bg = got_q.size(); nd = n_done; rc = rd144_cnt;
    start_sweep(32'd100, 32'd3, 16'd4, 1'b0);
    c = 0;
    while (rd144_cnt - rc < 2 && c < 3000) begin
      @(negedge clk_i);
      c++;
    end
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    s = n_stb;
    wait_done(100, "abort");
    repeat (4) @(negedge clk_i);
    chk("abort:ack_completed", pend, 0);
    chk("abort:no_more_strobes", n_stb - s, 0);
    chk("abort:writes", wr_q.size() - bw, 2);
    chk("abort:entries", got_q.size() - bg, 1);
    if (got_q.size() > bg && sum_q.size() > bw)
      chk("abort:entry0", got_q[bg], {16'd0, sum_q[bw]});
    chk("abort:done_pulses", n_done - nd, 1);
    chk("abort:busy_end", busy_o, 0);

    // ack watchdog
    dly_lo = 0; dly_hi = 0; busy_lo = 0; busy_hi = 0; ack_en = 1'b0; nd = n_done;
    start_sweep(32'd55, 32'd1, 16'd1, 1'b0);
`ifdef NA_SWEEP_TIMEOUT_EN
    repeat (1022) @(negedge clk_i);
    chk("tmo:err_before", timeout_err_o, 0);
    chk("tmo:done_before", done_o, 0);
    @(negedge clk_i);
    chk("tmo:err_at_1023", timeout_err_o, 1);
    chk("tmo:done_at_1023", done_o, 1);
    repeat (3) @(negedge clk_i);
    chk("tmo:sticky", timeout_err_o, 1);
    chk("tmo:busy_end", busy_o, 0);
    ack_en = 1'b1;
    repeat (5) @(negedge clk_i);
    bw = wr_q.size(); bg = got_q.size();
    start_sweep(32'd77, 32'd1, 16'd1, 1'b0);
    chk("tmo:cleared_by_start", timeout_err_o, 0);
    wait_done(2000, "tmo_after");
    repeat (4) @(negedge clk_i);
    check_sweep("tmo_after", bw, bg, 32'd77, 32'd1, 1);
`else
    repeat (10000) @(negedge clk_i);
    chk("notmo:still_busy", busy_o, 1);
    chk("notmo:no_err", timeout_err_o, 0);
    chk("notmo:no_done", n_done - nd, 0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    ack_en = 1'b1;
    repeat (2) @(negedge clk_i);
`endif

    // asynchronous reset in the middle of a read, two entries queued
    dly_lo = 1; dly_hi = 1; busy_lo = 0; busy_hi = 1; rdy_mode = 0;
    rc = rd144_cnt;
    start_sweep($urandom, $urandom, 16'd5, 1'b0);
    c = 0;
    while (rd144_cnt - rc < 3 && c < 3000) begin
      @(negedge clk_i);
      c++;
    end
    chk("rst_mid:valid_before", res_valid_o, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_mid:busy", busy_o, 0);
    chk("rst_mid:ren", m_ren_o, 0);
    chk("rst_mid:wen", m_wen_o, 0);
    chk("rst_mid:addr", m_addr_o, 0);
    chk("rst_mid:wdata", m_wdata_o, 0);
    chk("rst_mid:valid", res_valid_o, 0);
    chk("rst_mid:data", res_data_o, 0);
    chk("rst_mid:done", done_o, 0);
    chk("rst_mid:tmo", timeout_err_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    rdy_mode = 2;
    repeat (2) @(negedge clk_i);
    fs = $urandom; st = $urandom;
    bw = wr_q.size(); bg = got_q.size();
    start_sweep(fs, st, 16'd2, 1'b0);
    wait_done(3000, "post_rst");
    repeat (4) @(negedge clk_i);
    check_sweep("post_rst", bw, bg, fs, st, 2);

    chk("protocol", proto_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
